decode_buffer: RTL and testbench
================================

DECODE_BUFFER -- requirements
Module: decode_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of decoded-entry buffer slots; SHALL be a power of two, minimum 2.
REQ-002 Parameter ADDR_W, default 32, width of the instruction address passed through with each instruction.
REQ-003 Port clk  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port rdy  input  1  global enable; when low, all state SHALL hold.
REQ-006 Port update_stat  input  1  flush request, clearing all buffered entries.
REQ-007 Port in_valid  input  1  an instruction word is offered.
REQ-008 Port in_ready  output  1  the block can accept a word this cycle.
REQ-009 Port in_instr  input  32  raw RV32I instruction word.
REQ-010 Port in_pc  input  ADDR_W  address of in_instr.
REQ-011 Port out_valid  output  1  head entry is valid.
REQ-012 Port out_ready  input  1  consumer takes the head entry.
REQ-013 Ports out_opcode 7, out_rd 5, out_rs1 5, out_rs2 5, out_func3 3, out_func7 7, out_imm 32, out_pc ADDR_W, out_illegal 1  outputs  fields of the head entry.

Function
REQ-014 Input handshake SHALL occur when in_valid && in_ready && rdy && !update_stat; in_ready SHALL equal (count < DEPTH) combinationally, with no same-cycle pop bypass.
REQ-015 Output handshake SHALL occur when out_valid && out_ready && rdy && !update_stat; out_valid SHALL equal (count != 0).
REQ-016 Latency: a word accepted in cycle N into an empty buffer SHALL appear on the out_* ports in cycle N+1.
REQ-017 Decoding SHALL be combinational on in_instr and captured at push; out_* ports SHALL be driven from the storage entry at the read pointer.
REQ-018 Recognised opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, CALCI 0010011, CALC 0110011.
REQ-019 Immediates: I-type (JALR, LOAD, CALCI) = sign-extended instr[31:20], except CALCI with func3 1 or 5 = zero-extended instr[24:20]; S = sext{instr[31:25],instr[11:7]}; B = sext{instr[31],instr[7],instr[30:25],instr[11:8],0}; J = sext{instr[31],instr[19:12],instr[20],instr[30:21],0}; U = {instr[31:12],12'b0}; CALC imm = 0.
REQ-020 Field zeroing: rd = 0 for STORE and BRANCH; rs1 = 0 for LUI, AUIPC, JAL; rs2 = 0 for every type except CALC, STORE, BRANCH; func3 = 0 for LUI, AUIPC, JAL; func7 = 0 except CALC and CALCI-shift.
REQ-021 Unrecognised opcode SHALL set illegal = 1 with all other decoded fields 0; illegal SHALL also be set for CALC with func7 not 0000000/0100000, and for CALCI-shift with func7 not 0000000 (func3 1) or not 0000000/0100000 (func3 5).
REQ-022 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-023 When full, a pop SHALL not enable a same-cycle push; the word is accepted in the next cycle.
REQ-024 Flush (update_stat && rdy) SHALL set count and both pointers to 0 at the next edge, discarding any push or pop in the same cycle.
REQ-025 rdy low SHALL suppress push, pop and flush; outputs SHALL hold.

Reset
REQ-026 Reset SHALL asynchronously clear count and pointers, leaving out_valid = 0 and in_ready = 1.
REQ-027 Storage contents need not reset; out_* data fields are don't-care while out_valid = 0.

Structure
REQ-028 Opcode constants, field widths (OpcodeType, RegAddrType, Func3Type, Func7Type, WordType) and True/False SHALL come from the shared defines file.
REQ-029 Decode logic SHALL be a combinational sub-module, instr_field_decode, instantiated once ahead of the buffer storage.

Verification
REQ-030 Reset, push 0x00500093 (addi x1,x0,5) at pc 0x100 -> next cycle out_valid = 1, rd = 1, rs1 = 0, imm = 5, pc = 0x100, illegal = 0.
REQ-031 Push 0xFE000EE3 (beq x0,x0,-4) -> imm = 0xFFFFFFFC, rd = 0, rs2 = 0; push 0x40105093 (srai x1,x0,1) -> imm = 1, func7 = 0x20.
REQ-032 out_ready = 0, push DEPTH words -> in_ready = 0 once count = DEPTH; assert out_ready -> entries drain in push order, pointers wrap.
REQ-033 Push 0xFFFFFFFF -> illegal = 1 and all other decoded fields 0.
REQ-034 With 3 entries buffered, assert update_stat together with in_valid -> next cycle out_valid = 0, count = 0, the offered word is not stored.
REQ-035 Deassert rdy for 3 cycles during streaming -> no pushes or pops occur, outputs unchanged; assert rst low mid-stream -> out_valid = 0 immediately.

Source files
------------

// File: rtl/decode_buffer_pkg.sv
// Shared defines for the decode buffer: RV32I field types, opcode constants,
// boolean literals and the decoded-entry record stored in the buffer.
package decode_buffer_pkg;

    typedef logic [6:0]  OpcodeType;
    typedef logic [4:0]  RegAddrType;
    typedef logic [2:0]  Func3Type;
    typedef logic [6:0]  Func7Type;
    typedef logic [31:0] WordType;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    localparam OpcodeType OpLui    = 7'b0110111;
    localparam OpcodeType OpAuipc  = 7'b0010111;
    localparam OpcodeType OpJal    = 7'b1101111;
    localparam OpcodeType OpJalr   = 7'b1100111;
    localparam OpcodeType OpBranch = 7'b1100011;
    localparam OpcodeType OpLoad   = 7'b0000011;
    localparam OpcodeType OpStore  = 7'b0100011;
    localparam OpcodeType OpCalci  = 7'b0010011;
    localparam OpcodeType OpCalc   = 7'b0110011;

    // Legal func7 values for register ALU ops and arithmetic right shifts.
    localparam Func7Type Func7Zero = 7'b0000000;
    localparam Func7Type Func7Alt  = 7'b0100000;

    typedef struct packed {
        OpcodeType  opcode;
        RegAddrType rd;
        RegAddrType rs1;
        RegAddrType rs2;
        Func3Type   func3;
        Func7Type   func7;
        WordType    imm;
        logic       illegal;
    } DecodedType;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational RV32I field decoder.
// Ports:
//   instr   - raw instruction word
//   opcode, rd, rs1, rs2, func3, func7 - decoded fields, zeroed where unused
//   imm     - fully extended immediate for the instruction format
//   illegal - unrecognised opcode or reserved func7 encoding
module instr_field_decode
    import decode_buffer_pkg::*;
(
    input  logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [31:0] imm,
    output logic        illegal
);

    OpcodeType  raw_opcode;
    RegAddrType raw_rd;
    RegAddrType raw_rs1;
    RegAddrType raw_rs2;
    Func3Type   raw_func3;
    Func7Type   raw_func7;
    WordType    imm_i;
    WordType    imm_s;
    WordType    imm_b;
    WordType    imm_j;
    WordType    imm_u;

    assign raw_opcode = instr[6:0];
    assign raw_rd     = instr[11:7];
    assign raw_func3  = instr[14:12];
    assign raw_rs1    = instr[19:15];
    assign raw_rs2    = instr[24:20];
    assign raw_func7  = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    always_comb begin
        opcode  = '0;
        rd      = '0;
        rs1     = '0;
        rs2     = '0;
        func3   = '0;
        func7   = '0;
        imm     = '0;
        illegal = False;
        case (raw_opcode)
            OpLui, OpAuipc: begin
                opcode = raw_opcode;
                rd     = raw_rd;
                imm    = imm_u;
            end
            OpJal: begin
                opcode = raw_opcode;
                rd     = raw_rd;
                imm    = imm_j;
            end
            OpJalr, OpLoad: begin
                opcode = raw_opcode;
                rd     = raw_rd;
                rs1    = raw_rs1;
                func3  = raw_func3;
                imm    = imm_i;
            end
            OpBranch: begin
                opcode = raw_opcode;
                rs1    = raw_rs1;
                rs2    = raw_rs2;
                func3  = raw_func3;
                imm    = imm_b;
            end
            OpStore: begin
                opcode = raw_opcode;
                rs1    = raw_rs1;
                rs2    = raw_rs2;
                func3  = raw_func3;
                imm    = imm_s;
            end
            OpCalci: begin
                opcode = raw_opcode;
                rd     = raw_rd;
                rs1    = raw_rs1;
                func3  = raw_func3;
                if (raw_func3 == 3'd1 || raw_func3 == 3'd5) begin
                    // Shift-immediate: shamt in [24:20], func7 selects logical/arith.
                    imm   = {27'b0, instr[24:20]};
                    func7 = raw_func7;
                    if (raw_func3 == 3'd1) begin
                        illegal = (raw_func7 != Func7Zero);
                    end else begin
                        illegal = (raw_func7 != Func7Zero) && (raw_func7 != Func7Alt);
                    end
                end else begin
                    imm = imm_i;
                end
            end
            OpCalc: begin
                opcode  = raw_opcode;
                rd      = raw_rd;
                rs1     = raw_rs1;
                rs2     = raw_rs2;
                func3   = raw_func3;
                func7   = raw_func7;
                illegal = (raw_func7 != Func7Zero) && (raw_func7 != Func7Alt);
            end
            default: begin
                illegal = True;
            end
        endcase
    end

endmodule

// File: rtl/decode_buffer.sv
// Decode buffer: decodes incoming RV32I words and queues the decoded entries
// (with their addresses) in a DEPTH-slot circular buffer.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   rdy                 - global enable; all state holds while low
//   update_stat         - flush; drops every buffered entry
//   in_valid/in_ready   - input handshake for in_instr/in_pc
//   out_valid/out_ready - output handshake for the head entry fields out_*
module decode_buffer
    import decode_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,   // power of two, >= 2
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              update_stat,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [6:0]        out_opcode,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [2:0]        out_func3,
    output logic [6:0]        out_func7,
    output logic [31:0]       out_imm,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_illegal
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);

    DecodedType        decoded;
    DecodedType        entry_q [DEPTH];
    logic [ADDR_W-1:0] pc_q    [DEPTH];

    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [PtrW:0]   count_q, count_d;

    logic push;
    logic pop;
    logic flush;

    instr_field_decode u_decode (
        .instr   (in_instr),
        .opcode  (decoded.opcode),
        .rd      (decoded.rd),
        .rs1     (decoded.rs1),
        .rs2     (decoded.rs2),
        .func3   (decoded.func3),
        .func7   (decoded.func7),
        .imm     (decoded.imm),
        .illegal (decoded.illegal)
    );

    // in_ready deliberately ignores a same-cycle pop, so a full buffer
    // accepts the next word one cycle after the slot frees up.
    assign in_ready  = (count_q < DepthCnt);
    assign out_valid = (count_q != '0);

    assign flush = update_stat && rdy;
    assign push  = in_valid && in_ready && rdy && !update_stat;
    assign pop   = out_valid && out_ready && rdy && !update_stat;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // Pointer width equals log2(DEPTH), so increments wrap naturally.
            if (push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; its contents only matter while out_valid is high.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_q[wptr_q] <= decoded;
            pc_q[wptr_q]    <= in_pc;
        end
    end

    assign out_opcode  = entry_q[rptr_q].opcode;
    assign out_rd      = entry_q[rptr_q].rd;
    assign out_rs1     = entry_q[rptr_q].rs1;
    assign out_rs2     = entry_q[rptr_q].rs2;
    assign out_func3   = entry_q[rptr_q].func3;
    assign out_func7   = entry_q[rptr_q].func7;
    assign out_imm     = entry_q[rptr_q].imm;
    assign out_illegal = entry_q[rptr_q].illegal;
    assign out_pc      = pc_q[rptr_q];

endmodule

// File: tb/tb_decode_buffer.sv
module tb_decode_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        update_stat = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_func3;
    logic [6:0]  out_func7;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic        out_illegal;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    decode_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .update_stat (update_stat),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_func3   (out_func3),
        .out_func7   (out_func7),
        .out_imm     (out_imm),
        .out_pc      (out_pc),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm, input logic ill);
        exp_t e;
        e = '{op: op, rd: rd, rs1: rs1, rs2: rs2, f3: f3, f7: f7, imm: imm,
              pc: 32'h0, ill: ill};
        return e;
    endfunction

    function automatic exp_t head();
        exp_t a;
        a = '{op: out_opcode, rd: out_rd, rs1: out_rs1, rs2: out_rs2, f3: out_func3,
              f7: out_func7, imm: out_imm, pc: out_pc, ill: out_illegal};
        return a;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Scoreboard monitor: compares every consumed head entry with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready && rdy && !update_stat) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pop: actual pc %h required no entry", out_pc);
                end else begin
                    e = sb.pop_front();
                    check("pop_entry", head(), e);
                end
            end
        end
    end

    // Offers one word; returns how many cycles it waited for in_ready.
    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input exp_t e,
                        output int waits);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        @(negedge clk);
        while (!(in_ready && rdy) && n < 50) begin
            n++;
            @(negedge clk);
        end
        waits = n;
        if (n >= 50) begin
            check("push_timeout", 1, 0);
        end else begin
            @(posedge clk);
            #1;
            e.pc = pc;
            sb.push_back(e);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", (sb.size() == 0 && !out_valid), 1);
    endtask

    exp_t e_addi, e_beq, e_srai, e_ill, e_lui, e_sw, e_add, e_sub, e_mul, e_jal, e_lw;
    exp_t snap;
    int   w;

    initial begin
        e_addi = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h5, 1'b0);
        e_beq  = mk(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC, 1'b0);
        e_srai = mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd5, 7'h20, 32'h1, 1'b0);
        e_ill  = mk(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 1'b1);
        e_lui  = mk(7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 1'b0);
        e_sw   = mk(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h8, 1'b0);
        e_add  = mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0, 1'b0);
        e_sub  = mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0, 1'b0);
        e_mul  = mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h01, 32'h0, 1'b1);
        e_jal  = mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h8, 1'b0);
        e_lw   = mk(7'h03, 5'd5, 5'd2, 5'd0, 3'd2, 7'h00, 32'hFFFF_FFFC, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_out_valid", out_valid, 0);

        // Basic decode and one-cycle latency
        out_ready = 1'b1;
        push(32'h0050_0093, 32'h100, e_addi, w);
        check("latency_out_valid", out_valid, 1);
        push(32'hFE00_0EE3, 32'h104, e_beq, w);
        push(32'h4010_5093, 32'h108, e_srai, w);
        push(32'hFFFF_FFFF, 32'h10C, e_ill, w);
        wait_drain();

        // Fill to DEPTH, then drain with wrap-around
        out_ready = 1'b0;
        push(32'h1234_50B7, 32'h200, e_lui, w);
        push(32'h0020_A423, 32'h204, e_sw, w);
        push(32'h0020_81B3, 32'h208, e_add, w);
        push(32'h4020_81B3, 32'h20C, e_sub, w);
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        out_ready = 1'b1;
        push(32'h0080_00EF, 32'h210, e_jal, w);
        check("full_pop_no_bypass_wait", w, 1);
        push(32'h0220_81B3, 32'h214, e_mul, w);
        push(32'hFFC1_2283, 32'h218, e_lw, w);
        wait_drain();

        // Flush with a simultaneous push offer
        out_ready = 1'b0;
        push(32'h0050_0093, 32'h300, e_addi, w);
        push(32'hFE00_0EE3, 32'h304, e_beq, w);
        push(32'h4010_5093, 32'h308, e_srai, w);
        in_valid    = 1'b1;
        in_instr    = 32'h0020_81B3;
        in_pc       = 32'h30C;
        update_stat = 1'b1;
        @(posedge clk);
        #1;
        update_stat = 1'b0;
        in_valid    = 1'b0;
        sb.delete();
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        push(32'hFFFF_FFFF, 32'h310, e_ill, w);
        wait_drain();

        // rdy low freezes push, pop and flush
        out_ready = 1'b0;
        push(32'h1234_50B7, 32'h400, e_lui, w);
        push(32'h0020_A423, 32'h404, e_sw, w);
        snap        = head();
        rdy         = 1'b0;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_instr    = 32'h0020_81B3;
        in_pc       = 32'h408;
        for (int i = 0; i < 3; i++) begin
            update_stat = (i == 1);
            @(posedge clk);
            #1;
            check("stall_head", head(), snap);
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 1);
        end
        in_valid    = 1'b0;
        update_stat = 1'b0;
        rdy         = 1'b1;
        wait_drain();

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        push(32'h0020_81B3, 32'h500, e_add, w);
        push(32'h4020_81B3, 32'h504, e_sub, w);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_out_valid", out_valid, 0);
        check("async_reset_in_ready", in_ready, 1);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        push(32'hFFC1_2283, 32'h600, e_lw, w);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
